// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: load/store opcodes, LSU fault causes, LSU FSM states,
// plus small helpers for access-size alignment checks.
package mips_pkg;

  typedef enum logic [2:0] {LB, LBU, LH, LHU, LW, SB, SH, SW} lsu_op_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    TIMEOUT  = 2'd2
  } lsu_cause_t;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} lsu_state_t;

  function automatic logic is_store(lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // True when the low address bits violate the natural alignment of the access size.
  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] lo);
    case (op)
      LH, LHU, SH: return lo[0];
      LW, SW:      return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Clears the low address bits that the access size does not allow.
  function automatic logic [1:0] align_low(lsu_op_t op, logic [1:0] lo);
    case (op)
      LH, LHU, SH: return {lo[1], 1'b0};
      LW, SW:      return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/halfword lane of a little-endian
// word and sign- or zero-extends it to 32 bits. LW (and any store op) passes through.
module lsu_load_align
  import mips_pkg::*;
(
  input  lsu_op_t     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension chosen by the opcode.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'h0, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one single-beat access in flight over a valid/ready bus, with
// store lane replication, load extension, bus timeout and a one-cycle response.
// Build option LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault
// (cause MISALIGN) without touching the bus; otherwise the low bits are dropped.
module lsu
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  lsu_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [1:0]  resp_cause,
  output logic        busy
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  lsu_cause_t  cause_q, cause_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_data;

  lsu_load_align u_align (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (rdata_q),
    .data_o    (load_data)
  );

  // Next-state logic: request latch, bus handshakes and timeout counting.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          rdata_d = '0;
          cnt_d   = '0;
          cause_d = NONE;
`ifdef LSU_MISALIGN_TRAP_EN
          addr_d = req_addr;
          if (is_misaligned(req_op, req_addr[1:0])) begin
            cause_d = MISALIGN;
            state_d = StResp;
          end else begin
            state_d = StReq;
          end
`else
          addr_d  = {req_addr[31:2], align_low(req_op, req_addr[1:0])};
          state_d = StReq;
`endif
        end
      end
      StReq: begin
        // A handshake on the final counted cycle still wins over the timeout.
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = is_store(op_q) ? StResp : StWait;
        end else if (cnt_q == TimeoutLast) begin
          cause_d = TIMEOUT;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          cause_d = TIMEOUT;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any outstanding bus transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= LB;
      cause_q <= NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from state; everything is held at 0 while reset is asserted.
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b0;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wstrb  = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_we    = 1'b0;
    resp_rd    = '0;
    resp_data  = '0;
    resp_fault = 1'b0;
    resp_cause = '0;
    if (!reset) begin
      req_ready = (state_q == StIdle);
      busy      = (state_q != StIdle);
      if (state_q == StReq) begin
        mem_valid = 1'b1;
        mem_write = is_store(op_q);
        mem_addr  = {addr_q[31:2], 2'b00};
        case (op_q)
          SB: begin
            mem_wdata = {4{wdata_q[7:0]}};
            mem_wstrb = 4'b0001 << addr_q[1:0];
          end
          SH: begin
            mem_wdata = {2{wdata_q[15:0]}};
            mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
          end
          SW: begin
            mem_wdata = wdata_q;
            mem_wstrb = 4'b1111;
          end
          default: ;
        endcase
      end
      if (state_q == StResp) begin
        resp_valid = 1'b1;
        resp_rd    = rd_q;
        resp_fault = (cause_q != NONE);
        resp_cause = cause_q;
        resp_we    = !is_store(op_q) && (cause_q == NONE);
        resp_data  = resp_we ? load_data : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: table of single accesses plus hand-written timeout,
// late-handshake and reset-in-WAIT sequences. Responses are checked by a scoreboard.
module tb_lsu;
  import mips_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  lsu_op_t     req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_we, resp_fault, busy;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  resp_cause;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_we    (resp_we),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .resp_cause (resp_cause),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    lsu_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        trap;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic        fault;
    logic [1:0]  cause;
    logic [4:0]  rd;
    int          cyc;
  } resp_t;

  resp_t sb_q[$];
  vec_t  vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    resp_t e;
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 want none (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("resp_data", resp_data, e.data);
        check("resp_we", resp_we, e.we);
        check("resp_fault", resp_fault, e.fault);
        check("resp_cause", resp_cause, e.cause);
        check("resp_rd", resp_rd, e.rd);
      end
    end
  end

  function automatic vec_t mk(lsu_op_t op, logic [31:0] addr, logic [31:0] wdata,
                              logic [4:0] rd, logic [31:0] rdata, logic mis,
                              logic [31:0] maddr, logic [3:0] wstrb, logic [31:0] mwdata,
                              logic [31:0] data);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    v.trap = mis;
`else
    v.trap = 1'b0;
`endif
    v.exp_maddr = maddr; v.exp_wstrb = wstrb; v.exp_mwdata = mwdata; v.exp_data = data;
    return v;
  endfunction

  task automatic wait_resp(input string name);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_no_resp: got no resp_valid want resp_valid within 12 cycles", name);
    end
  endtask

  task automatic access(input vec_t v);
    logic  is_st;
    int    a;
    resp_t e;
    is_st = (v.op == SB) || (v.op == SH) || (v.op == SW);
    @(negedge clk);
    check("req_ready", req_ready, 1);
    req_valid = 1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    mem_ready = !v.trap;
    @(posedge clk); #1;
    req_valid = 0;
    a = cyc;
    e.rd    = v.rd;
    e.fault = v.trap;
    e.cause = v.trap ? 2'd1 : 2'd0;
    e.we    = !is_st && !v.trap;
    e.data  = e.we ? v.exp_data : 32'h0;
    e.cyc   = v.trap ? a : (is_st ? a + 1 : a + 2);
    sb_q.push_back(e);
    if (v.trap) begin
      @(negedge clk);
      check("trap_mem_valid", mem_valid, 0);
      check("trap_resp_valid", resp_valid, 1);
    end else begin
      @(negedge clk);
      check("mem_valid", mem_valid, 1);
      check("busy", busy, 1);
      check("mem_write", mem_write, is_st);
      check("mem_addr", mem_addr, v.exp_maddr);
      check("mem_wstrb", mem_wstrb, v.exp_wstrb);
      if (is_st) check("mem_wdata", mem_wdata, v.exp_mwdata);
      @(posedge clk); #1;
      mem_ready = 0;
      if (!is_st) begin
        mem_rvalid = 1; mem_rdata = v.rdata;
        @(posedge clk); #1;
        mem_rvalid = 0; mem_rdata = 0;
      end
      wait_resp("access");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int a;
    resp_t e;

    vecs.push_back(mk(SW,  32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0, 32'h100, 4'b1111,
                      32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(LB,  32'h103, 32'h0, 5'd5, 32'h80FF_0000, 0, 32'h100, 4'b0000, 32'h0,
                      32'hFFFF_FF80));
    vecs.push_back(mk(LBU, 32'h103, 32'h0, 5'd6, 32'h80FF_0000, 0, 32'h100, 4'b0000, 32'h0,
                      32'h0000_0080));
    vecs.push_back(mk(SH,  32'h202, 32'h1234ABCD, 5'd2, 32'h0, 0, 32'h200, 4'b1100,
                      32'hABCDABCD, 32'h0));
    vecs.push_back(mk(LH,  32'h102, 32'h0, 5'd7, 32'h80FF_0000, 0, 32'h100, 4'b0000, 32'h0,
                      32'hFFFF_80FF));
    vecs.push_back(mk(LHU, 32'h102, 32'h0, 5'd8, 32'h80FF_0000, 0, 32'h100, 4'b0000, 32'h0,
                      32'h0000_80FF));
    vecs.push_back(mk(LW,  32'h104, 32'h0, 5'd9, 32'h1234_5678, 0, 32'h104, 4'b0000, 32'h0,
                      32'h1234_5678));
    vecs.push_back(mk(SB,  32'h301, 32'h0000_00A5, 5'd3, 32'h0, 0, 32'h300, 4'b0010,
                      32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(LB,  32'h101, 32'h0, 5'd10, 32'h0000_7F00, 0, 32'h100, 4'b0000, 32'h0,
                      32'h0000_007F));
    vecs.push_back(mk(LH,  32'h100, 32'h0, 5'd11, 32'h0000_FFFE, 0, 32'h100, 4'b0000, 32'h0,
                      32'hFFFF_FFFE));
    vecs.push_back(mk(SB,  32'h303, 32'h1122_3344, 5'd4, 32'h0, 0, 32'h300, 4'b1000,
                      32'h4444_4444, 32'h0));
    // Misaligned accesses: fault under the trap build, low bits dropped otherwise.
    vecs.push_back(mk(LW,  32'h101, 32'h0, 5'd12, 32'hCAFE_F00D, 1, 32'h100, 4'b0000, 32'h0,
                      32'hCAFE_F00D));
    vecs.push_back(mk(SH,  32'h203, 32'h0000_5566, 5'd13, 32'h0, 1, 32'h200, 4'b1100,
                      32'h5566_5566, 32'h0));
    vecs.push_back(mk(LH,  32'h105, 32'h0, 5'd14, 32'h8001_7FFF, 1, 32'h104, 4'b0000, 32'h0,
                      32'h0000_7FFF));

    reset = 1; req_valid = 0; req_op = LB; req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    @(posedge clk); #1;
    reset = 0;

    foreach (vecs[i]) access(vecs[i]);

    // Bus never accepts a store: TO cycles of mem_valid, then a timeout fault.
    @(negedge clk);
    req_valid = 1; req_op = SW; req_addr = 32'h400; req_wdata = 32'h1; req_rd = 5'd20;
    mem_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    a = cyc;
    e = '{data: 32'h0, we: 0, fault: 1, cause: 2'd2, rd: 5'd20, cyc: a + TO};
    sb_q.push_back(e);
    n = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      if (mem_valid) n++;
    end
    check("req_timeout_mem_valid_cycles", n, TO);
    wait_resp("req_timeout");

    // Load accepted by the bus but no read data: timeout out of WAIT.
    @(negedge clk);
    req_valid = 1; req_op = LW; req_addr = 32'h404; req_rd = 5'd21; mem_ready = 1;
    @(posedge clk); #1;
    req_valid = 0;
    a = cyc;
    e = '{data: 32'h0, we: 0, fault: 1, cause: 2'd2, rd: 5'd21, cyc: a + 1 + TO};
    sb_q.push_back(e);
    @(posedge clk); #1;
    mem_ready = 0;
    wait_resp("wait_timeout");

    // Handshake on the last counted REQ cycle beats the timeout.
    @(negedge clk);
    req_valid = 1; req_op = SW; req_addr = 32'h408; req_wdata = 32'h2; req_rd = 5'd22;
    mem_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    a = cyc;
    e = '{data: 32'h0, we: 0, fault: 0, cause: 2'd0, rd: 5'd22, cyc: a + TO};
    sb_q.push_back(e);
    for (int k = 0; k < TO - 1; k++) begin
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    wait_resp("late_handshake");

    // Reset while a load waits for data; a later rvalid must be ignored.
    @(negedge clk);
    req_valid = 1; req_op = LW; req_addr = 32'h500; req_rd = 5'd23; mem_ready = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    mem_ready = 0;
    reset = 1;
    @(negedge clk);
    check("wait_rst_busy", busy, 0);
    check("wait_rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    check("post_rst_resp_valid2", resp_valid, 0);
    check("post_rst_busy", busy, 0);

    // Normal operation resumes after the abandoned access.
    access(mk(LBU, 32'h102, 32'h0, 5'd24, 32'h00C3_0000, 0, 32'h100, 4'b0000, 32'h0,
              32'h0000_00C3));

    @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the MIPS datapath, directly downstream of the ALU. It takes the ALU's effective address (base + offset) and the store operand, then performs a single-beat memory access over a valid/ready bus. It aligns byte/halfword data and sign- or zero-extends loads, and delivers a one-cycle writeback response with fault reporting. One access is in flight at a time; `busy` stalls the pipeline.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles the unit waits in REQ or WAIT before a bus timeout fault; range 1..255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  access request from execute stage.
- `req_ready`  out  1  unit can accept; equals `state==IDLE && !reset`.
- `req_op`  in  3  `lsu_op_t`: LB, LBU, LH, LHU, LW, SB, SH, SW.
- `req_addr`  in  32  effective address (ALU `out`).
- `req_wdata`  in  32  store operand (rt).
- `req_rd`  in  5  load destination register.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus accepts the request.
- `mem_write`  out  1  1 = store.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wstrb`  out  4  byte enables; 0 for loads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rvalid`  in  1  read data valid; sampled only in WAIT.
- `mem_rdata`  in  32  read word.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_we`  out  1  register write enable: load completed without a fault.
- `resp_rd`  out  5  latched `req_rd`.
- `resp_data`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  access failed.
- `resp_cause`  out  2  0 none, 1 misaligned, 2 bus timeout.
- `busy`  out  1  `state!=IDLE`.

## Operation
- FSM states and transitions:
  - IDLE: on `req_valid`, latch op/addr/wdata/rd and go to REQ; if the access is misaligned (macro on), go straight to RESP with cause 1.
  - REQ: drive `mem_valid` and hold all `mem_*` stable until `mem_ready`. A store then goes to RESP; a load goes to WAIT.
  - WAIT: on `mem_rvalid`, capture `mem_rdata` and go to RESP.
  - RESP: drive `resp_valid` for one cycle, then go to IDLE.
- Little-endian lanes: byte k (`addr[1:0]==k`) occupies bits `[8k+7:8k]`. Halfword at `addr[1]` occupies `[16h+15:16h]`.
- Store data and strobes:
  - SB: wdata `{4{b}}`, wstrb `4'b0001<<addr[1:0]`.
  - SH: wdata `{2{h}}`, wstrb `4'b0011<<{addr[1],1'b0}`.
  - SW: wstrb `4'b1111`.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout:
  - 8-bit counter, cleared on entry to REQ and to WAIT, incremented every cycle spent in those states.
  - When the count reaches `TIMEOUT_CYCLES-1` without `mem_ready` (REQ) or `mem_rvalid` (WAIT), go to RESP with cause 2.
  - A handshake in that same final cycle wins over the timeout.
- Reset: forces IDLE from any state and abandons the outstanding bus transaction; a later `mem_rvalid` is ignored.

## Timing
- Reset values: every output is 0, including `req_ready` during the reset cycle.
- Store, with `mem_ready` present on the first REQ cycle: accepted at edge N, `mem_valid` high in cycle N+1, `resp_valid` in cycle N+2.
- Load: `mem_rvalid` is only legal from the cycle after the `mem_ready` handshake. With `rvalid` arriving in that cycle (N+2), `resp_valid` is in cycle N+3.
- Misaligned request: `resp_valid` in cycle N+1; `mem_valid` is never asserted.
- Throughput: the next request is accepted in the cycle after RESP.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`, and LW/SW with `addr[1:0]!=0`, complete with `resp_fault=1`, cause 1.
  - No bus access is made; `resp_we=0`.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - The offending low address bits are forced to 0 (halfword: `addr[0]`; word: `addr[1:0]`) and the access proceeds.
  - Cause 1 is never produced.

## Structure
- Shared package `mips_pkg`: `lsu_op_t` enum, `lsu_cause_t` (NONE/MISALIGN/TIMEOUT), FSM state typedef.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension, taking (op, addr[1:0], rdata). It is reused by the verification model.

## Test plan
- SW addr 0x100 wdata 0xDEADBEEF, `mem_ready`=1 -> mem_addr 0x100, wstrb 1111, `resp_valid` 2 cycles after accept, `resp_we`=0.
- LB addr 0x103, rdata 0x80FF_0000 -> resp_data 0xFFFF_FF80, resp_we=1, resp_rd echoed; LBU at the same address -> 0x0000_0080.
- SH addr 0x202 wdata 0x1234ABCD -> wdata 0xABCDABCD, wstrb 1100.
- LW addr 0x101 with macro on -> fault cause 1 in cycle N+1, no `mem_valid`; with macro off -> mem_addr 0x100, normal load.
- `TIMEOUT_CYCLES`=4, `mem_ready` held 0 -> `mem_valid` for 4 cycles, then `resp_fault`, cause 2.
- Reset asserted in WAIT, then `mem_rvalid` pulses -> no `resp_valid`; `req_ready`=1 the cycle after reset deasserts.
